// File: rtl/f2h_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : f2h_sdram_arbiter
// Purpose  : Shares one Avalon-MM burst read port (HPS f2h_sdram) between two
//            read masters. Master 0 (video fetch) has fixed priority. Master 1
//            is granted ahead of master 0 once it has waited STARVE_LIMIT
//            cycles. A small FIFO tracks accepted bursts so that returning
//            readdatavalid beats go to the master that issued each burst.
// Ports    : clk, rst                     - clock, sync active-high reset
//            m0_* / m1_*                  - requester-side Avalon read ports
//            s_*                          - f2h_sdram-side Avalon read port
//            protocol_err                 - sticky, burstcount==0 seen
//            stat_*                       - burst/starvation statistics
// Options  : F2H_ARB_STATS_EN             - enables the stat_* counters;
//                                           when undefined they read 0
// Revision : 1.0 - initial release
// ============================================================================
module f2h_sdram_arbiter #(
  parameter int ADDR_W          = 27,
  parameter int DATA_W          = 256,
  parameter int BURST_W         = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  m0_address,
  input  logic [BURST_W-1:0] m0_burstcount,
  input  logic               m0_read,
  output logic               m0_waitrequest,
  output logic [DATA_W-1:0]  m0_readdata,
  output logic               m0_readdatavalid,
  input  logic [ADDR_W-1:0]  m1_address,
  input  logic [BURST_W-1:0] m1_burstcount,
  input  logic               m1_read,
  output logic               m1_waitrequest,
  output logic [DATA_W-1:0]  m1_readdata,
  output logic               m1_readdatavalid,
  output logic [ADDR_W-1:0]  s_address,
  output logic [BURST_W-1:0] s_burstcount,
  output logic               s_read,
  input  logic               s_waitrequest,
  input  logic [DATA_W-1:0]  s_readdata,
  input  logic               s_readdatavalid,
  output logic               protocol_err,
  output logic [31:0]        stat_m0_bursts,
  output logic [31:0]        stat_m1_bursts,
  output logic [15:0]        stat_starve_grants
);

  localparam int         PTR_W      = $clog2(MAX_OUTSTANDING);
  localparam int         CNT_W      = PTR_W + 1;
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  typedef enum logic [0:0] {ARB = 1'b0, CMD = 1'b1} state_t;

  state_t             state_q, state_d;
  logic               grant_id_q, grant_id_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [BURST_W-1:0] beat_q, beat_d;
  logic [7:0]         starve_q, starve_d;
  logic               protocol_err_q, protocol_err_d;

  logic               fifo_owner_q [MAX_OUTSTANDING];
  logic [BURST_W-1:0] fifo_len_q   [MAX_OUTSTANDING];

  logic m0_elig, m1_elig, fifo_empty, fifo_room, starve_hit;
  logic in_cmd, sel_read, accept, beat_valid, pop, arb_grant;

  assign m0_elig    = m0_read & (m0_burstcount != '0);
  assign m1_elig    = m1_read & (m1_burstcount != '0);
  assign fifo_empty = (count_q == '0);
  // Registered occupancy only: a pop in this same cycle does not open a slot.
  assign fifo_room  = (count_q < CNT_W'(MAX_OUTSTANDING));
  assign starve_hit = m1_elig & (starve_q == STARVE_MAX);
  assign arb_grant  = (state_q == ARB) & fifo_room & (m0_elig | m1_elig);

  // Command phase: the granted master drives the slave port directly.
  assign in_cmd       = ~rst & (state_q == CMD);
  assign sel_read     = grant_id_q ? m1_read : m0_read;
  assign s_read       = in_cmd & sel_read;
  assign s_address    = grant_id_q ? m1_address : m0_address;
  assign s_burstcount = grant_id_q ? m1_burstcount : m0_burstcount;
  assign accept       = s_read & ~s_waitrequest;

  assign m0_waitrequest = ~(in_cmd & ~grant_id_q) | s_waitrequest;
  assign m1_waitrequest = ~(in_cmd &  grant_id_q) | s_waitrequest;

  // Response routing: the FIFO head owns every beat until its length is used.
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign beat_valid       = ~rst & s_readdatavalid & ~fifo_empty;
  assign m0_readdatavalid = beat_valid & ~fifo_owner_q[rd_ptr_q];
  assign m1_readdatavalid = beat_valid &  fifo_owner_q[rd_ptr_q];
  assign pop              = beat_valid &
                            (beat_q == fifo_len_q[rd_ptr_q] - BURST_W'(1));
  assign protocol_err     = protocol_err_q;

  always_comb begin
    state_d        = state_q;
    grant_id_d     = grant_id_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    beat_d         = beat_q;
    starve_d       = starve_q;
    protocol_err_d = protocol_err_q |
                     (m0_read & (m0_burstcount == '0)) |
                     (m1_read & (m1_burstcount == '0));

    case (state_q)
      ARB: if (arb_grant) begin
        state_d    = CMD;
        grant_id_d = starve_hit | ~m0_elig;
      end
      CMD: if (accept || !sel_read) state_d = ARB;  // dropped read: no push
      default: state_d = ARB;
    endcase

    if (accept) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (pop)             beat_d = '0;
    else if (beat_valid) beat_d = beat_q + BURST_W'(1);

    // Waiting time of master 1; frozen while it holds the grant.
    if (!m1_read)                           starve_d = '0;
    else if (accept && grant_id_q)          starve_d = '0;
    else if (!(in_cmd && grant_id_q) && starve_q != STARVE_MAX)
                                            starve_d = starve_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ARB;
      grant_id_q     <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      beat_q         <= '0;
      starve_q       <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_id_q     <= grant_id_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      beat_q         <= beat_d;
      starve_q       <= starve_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  // Burst-tracking storage; contents are qualified by count_q.
  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_owner_q[wr_ptr_q] <= grant_id_q;
      fifo_len_q[wr_ptr_q]   <= s_burstcount;
    end
  end

`ifdef F2H_ARB_STATS_EN
  logic [31:0] stat_m0_q, stat_m0_d, stat_m1_q, stat_m1_d;
  logic [15:0] stat_sg_q, stat_sg_d;

  always_comb begin
    stat_m0_d = stat_m0_q + 32'(accept & ~grant_id_q);
    stat_m1_d = stat_m1_q + 32'(accept &  grant_id_q);
    // Counted only when the guard actually overrides an eligible master 0.
    stat_sg_d = stat_sg_q + 16'(arb_grant & starve_hit & m0_elig);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_m0_q <= '0;
      stat_m1_q <= '0;
      stat_sg_q <= '0;
    end else begin
      stat_m0_q <= stat_m0_d;
      stat_m1_q <= stat_m1_d;
      stat_sg_q <= stat_sg_d;
    end
  end

  assign stat_m0_bursts     = stat_m0_q;
  assign stat_m1_bursts     = stat_m1_q;
  assign stat_starve_grants = stat_sg_q;
`else
  assign stat_m0_bursts     = '0;
  assign stat_m1_bursts     = '0;
  assign stat_starve_grants = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_f2h_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_f2h_sdram_arbiter
// Purpose  : Randomized self-checking bench for f2h_sdram_arbiter. A
//            transaction-level reference (queue of outstanding bursts, integer
//            starvation timer, grant owner) predicts every cycle's outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_f2h_sdram_arbiter;

  localparam int ADDR_W = 27;
  localparam int DATA_W = 64;
  localparam int BURST_W = 8;
  localparam int MAXO = 4;
  localparam int LIMIT = 16;

  logic clk = 1'b0;
  logic rst;
  logic [ADDR_W-1:0] m0_address, m1_address, s_address;
  logic [BURST_W-1:0] m0_burstcount, m1_burstcount, s_burstcount;
  logic m0_read, m1_read, m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata, s_readdata;
  logic m0_readdatavalid, m1_readdatavalid;
  logic s_read, s_waitrequest, s_readdatavalid, protocol_err;
  logic [31:0] stat_m0_bursts, stat_m1_bursts;
  logic [15:0] stat_starve_grants;

  f2h_sdram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W),
    .MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_address(m0_address), .m0_burstcount(m0_burstcount), .m0_read(m0_read),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_burstcount(m1_burstcount), .m1_read(m1_read),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_burstcount(s_burstcount), .s_read(s_read),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid),
    .protocol_err(protocol_err), .stat_m0_bursts(stat_m0_bursts),
    .stat_m1_bursts(stat_m1_bursts), .stat_starve_grants(stat_starve_grants)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int  q_own[$];
  int  q_len[$];
  int  mdl_beats;      // beats already delivered for the head burst
  bit  mdl_busy;       // a grant is being presented to the sdram port
  int  mdl_owner;
  int  mdl_wait;       // cycles master 1 has been waiting
  bit  mdl_perr;
  longint mdl_n0, mdl_n1, mdl_nsg;

  task automatic model_reset();
    q_own.delete(); q_len.delete();
    mdl_beats = 0; mdl_busy = 0; mdl_owner = 0; mdl_wait = 0; mdl_perr = 0;
    mdl_n0 = 0; mdl_n1 = 0; mdl_nsg = 0;
  endtask

  task automatic run_cycles(input int n, input int p0, input int p1,
                            input int pwait, input int prdv,
                            input bit m1_zero, input bit do_rst);
    for (int c = 0; c < n; c++) begin
      bit cmd, e_sread, routed, acc, e0, e1, forced;
      int own, req_own, occ;
      @(negedge clk);
      rst             = do_rst;
      m0_read         = ($urandom_range(99) < p0);
      m1_read         = ($urandom_range(99) < p1);
      m0_address      = ADDR_W'($urandom);
      m1_address      = ADDR_W'($urandom);
      m0_burstcount   = BURST_W'($urandom_range(4, 1));
      m1_burstcount   = m1_zero ? '0 : BURST_W'($urandom_range(4, 1));
      s_waitrequest   = ($urandom_range(99) < pwait);
      s_readdatavalid = ($urandom_range(99) < prdv);
      s_readdata      = {$urandom, $urandom};
      #1;
      // Expected outputs for this cycle
      cmd     = !rst && mdl_busy;
      req_own = mdl_owner;
      e_sread = cmd && (req_own == 1 ? m1_read : m0_read);
      routed  = !rst && s_readdatavalid && q_own.size() > 0;
      own     = (q_own.size() > 0) ? q_own[0] : 0;
      check_val("s_read", s_read, e_sread);
      check_val("m0_waitreq", m0_waitrequest, !(cmd && req_own == 0) || s_waitrequest);
      check_val("m1_waitreq", m1_waitrequest, !(cmd && req_own == 1) || s_waitrequest);
      check_val("m0_rdv", m0_readdatavalid, routed && own == 0);
      check_val("m1_rdv", m1_readdatavalid, routed && own == 1);
      check_val("protocol_err", protocol_err, mdl_perr);
      if (e_sread) begin
        check_val("s_address", s_address, req_own == 1 ? m1_address : m0_address);
        check_val("s_burstcount", s_burstcount, req_own == 1 ? m1_burstcount : m0_burstcount);
      end
      if (routed)
        check_val("readdata", own == 1 ? m1_readdata : m0_readdata, s_readdata);
`ifdef F2H_ARB_STATS_EN
      check_val("stat_m0", stat_m0_bursts, mdl_n0);
      check_val("stat_m1", stat_m1_bursts, mdl_n1);
      check_val("stat_sg", stat_starve_grants, mdl_nsg);
`else
      check_val("stat_m0", stat_m0_bursts, 0);
      check_val("stat_m1", stat_m1_bursts, 0);
      check_val("stat_sg", stat_starve_grants, 0);
`endif
      // Advance the model to the state after the coming clock edge
      if (rst) begin
        model_reset();
      end else begin
        acc = e_sread && !s_waitrequest;
        e0  = m0_read && m0_burstcount != 0;
        e1  = m1_read && m1_burstcount != 0;
        occ = q_own.size();
        if ((m0_read && m0_burstcount == 0) || (m1_read && m1_burstcount == 0))
          mdl_perr = 1;
        if (!mdl_busy) begin
          if (occ < MAXO && (e0 || e1)) begin
            forced    = e1 && mdl_wait == LIMIT;
            mdl_owner = (forced || !e0) ? 1 : 0;
            mdl_busy  = 1;
            if (forced && e0) mdl_nsg++;
          end
        end else if (acc || !e_sread) begin
          mdl_busy = 0;
        end
        // starvation timer from pre-edge grant status
        if (!m1_read)                         mdl_wait = 0;
        else if (acc && req_own == 1)         mdl_wait = 0;
        else if (!(cmd && req_own == 1) && mdl_wait < LIMIT) mdl_wait++;
        if (routed) begin
          mdl_beats++;
          if (mdl_beats == q_len[0]) begin
            void'(q_own.pop_front()); void'(q_len.pop_front());
            mdl_beats = 0;
          end
        end
        if (acc) begin
          q_own.push_back(req_own);
          q_len.push_back(int'(req_own == 1 ? m1_burstcount : m0_burstcount));
          if (req_own == 1) mdl_n1++; else mdl_n0++;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    m0_read = 0; m1_read = 0; m0_address = '0; m1_address = '0;
    m0_burstcount = '0; m1_burstcount = '0;
    s_waitrequest = 0; s_readdatavalid = 0; s_readdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    run_cycles(2,   0,   0,   0,   0, 0, 1);  // reset state
    run_cycles(400, 50,  50,  25,  50, 0, 0);  // mixed random traffic
    run_cycles(300, 100, 100, 0,   50, 0, 0);  // contention, starvation guard
    run_cycles(60,  100, 100, 20,  0,  0, 0);  // no returns: FIFO fills
    run_cycles(150, 60,  60,  20,  90, 0, 0);  // drain
    run_cycles(40,  100, 100, 0,   30, 0, 0);  // build outstanding bursts
    run_cycles(2,   100, 100, 0,   100, 0, 1); // reset mid-burst
    run_cycles(30,  0,   0,   0,   100, 0, 0); // stray beats after reset
    run_cycles(120, 60,  70,  20,  60, 1, 0);  // m1 burstcount==0
    run_cycles(2,   0,   0,   0,   50, 0, 1);  // clears protocol_err
    run_cycles(200, 70,  70,  30,  60, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
